// File: rtl/ctrl_pipe_regs.sv
// ID/EX -> EX/MEM -> MEM/WB control pipeline registers with bubble, flush and stall handling.
// Optional performance counters (perf_bubbles, perf_flushes) are enabled with `define CTRL_PIPE_PERF_EN.
module ctrl_pipe_regs #(
  parameter int RD_W   = 5,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            id_alu_src,
  input  logic            id_mem2reg,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_jalr_mode,
  input  logic            id_jal_mode,
  input  logic            id_lui_mode,
  input  logic [3:0]      id_write_enable,
  input  logic [4:0]      id_read_enable,
  input  logic [1:0]      id_aluop,
  input  logic [1:0]      id_writeback,
  input  logic [RD_W-1:0] id_rd,
  input  logic            bubble,
  input  logic            flush,
  input  logic            stall_all,
  output logic            ex_valid,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic            ex_jalr_mode,
  output logic            ex_jal_mode,
  output logic            ex_lui_mode,
  output logic [1:0]      ex_aluop,
  output logic            mem_valid,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic [3:0]      mem_write_enable,
  output logic [4:0]      mem_read_enable,
  output logic            mem_reg_write,
  output logic [RD_W-1:0] mem_rd,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            wb_mem2reg,
  output logic [1:0]      wb_writeback,
  output logic [RD_W-1:0] wb_rd
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_bubbles,
  output logic [PERF_W-1:0] perf_flushes
`endif
);

  typedef struct packed {
    logic            valid;
    logic            aluSrc;
    logic            mem2reg;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic            jalrMode;
    logic            jalMode;
    logic            luiMode;
    logic [3:0]      writeEnable;
    logic [4:0]      readEnable;
    logic [1:0]      aluop;
    logic [1:0]      writeback;
    logic [RD_W-1:0] rd;
  } idEx_t;

  typedef struct packed {
    logic            valid;
    logic            memRead;
    logic            memWrite;
    logic [3:0]      writeEnable;
    logic [4:0]      readEnable;
    logic            regWrite;
    logic            mem2reg;
    logic [1:0]      writeback;
    logic [RD_W-1:0] rd;
  } exMem_t;

  typedef struct packed {
    logic            valid;
    logic            regWrite;
    logic            mem2reg;
    logic [1:0]      writeback;
    logic [RD_W-1:0] rd;
  } memWb_t;

  idEx_t  r_idEx;
  exMem_t r_exMem;
  memWb_t r_memWb;
  idEx_t  w_idCapture;

  // Anything not a real, surviving instruction becomes an all-zero NOP, so
  // every later stage sees zero enables for invalid slots without gating.
  always_comb begin
    w_idCapture = '0;
    if (id_valid && !bubble && !flush) begin
      w_idCapture.valid       = 1'b1;
      w_idCapture.aluSrc      = id_alu_src;
      w_idCapture.mem2reg     = id_mem2reg;
      w_idCapture.regWrite    = id_reg_write && (id_rd != '0);
      w_idCapture.memRead     = id_mem_read;
      w_idCapture.memWrite    = id_mem_write;
      w_idCapture.branch      = id_branch;
      w_idCapture.jalrMode    = id_jalr_mode;
      w_idCapture.jalMode     = id_jal_mode;
      w_idCapture.luiMode     = id_lui_mode;
      w_idCapture.writeEnable = id_write_enable;
      w_idCapture.readEnable  = id_read_enable;
      w_idCapture.aluop       = id_aluop;
      w_idCapture.writeback   = id_writeback;
      w_idCapture.rd          = id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idEx  <= '0;
      r_exMem <= '0;
      r_memWb <= '0;
    end else if (!stall_all) begin
      r_idEx              <= w_idCapture;
      r_exMem.valid       <= r_idEx.valid;
      r_exMem.memRead     <= r_idEx.memRead;
      r_exMem.memWrite    <= r_idEx.memWrite;
      r_exMem.writeEnable <= r_idEx.writeEnable;
      r_exMem.readEnable  <= r_idEx.readEnable;
      r_exMem.regWrite    <= r_idEx.regWrite;
      r_exMem.mem2reg     <= r_idEx.mem2reg;
      r_exMem.writeback   <= r_idEx.writeback;
      r_exMem.rd          <= r_idEx.rd;
      r_memWb.valid       <= r_exMem.valid;
      r_memWb.regWrite    <= r_exMem.regWrite;
      r_memWb.mem2reg     <= r_exMem.mem2reg;
      r_memWb.writeback   <= r_exMem.writeback;
      r_memWb.rd          <= r_exMem.rd;
    end
  end

  assign ex_valid         = r_idEx.valid;
  assign ex_alu_src       = r_idEx.aluSrc;
  assign ex_branch        = r_idEx.branch;
  assign ex_jalr_mode     = r_idEx.jalrMode;
  assign ex_jal_mode      = r_idEx.jalMode;
  assign ex_lui_mode      = r_idEx.luiMode;
  assign ex_aluop         = r_idEx.aluop;
  assign mem_valid        = r_exMem.valid;
  assign mem_mem_read     = r_exMem.memRead;
  assign mem_mem_write    = r_exMem.memWrite;
  assign mem_write_enable = r_exMem.writeEnable;
  assign mem_read_enable  = r_exMem.readEnable;
  assign mem_reg_write    = r_exMem.regWrite;
  assign mem_rd           = r_exMem.rd;
  assign wb_valid         = r_memWb.valid;
  assign wb_reg_write     = r_memWb.regWrite;
  assign wb_mem2reg       = r_memWb.mem2reg;
  assign wb_writeback     = r_memWb.writeback;
  assign wb_rd            = r_memWb.rd;

`ifdef CTRL_PIPE_PERF_EN
  logic [PERF_W-1:0] r_perfBubbles;
  logic [PERF_W-1:0] r_perfFlushes;

  // A combined flush+bubble inserts one NOP and is accounted as a flush only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perfBubbles <= '0;
      r_perfFlushes <= '0;
    end else if (!stall_all) begin
      if (flush) begin
        r_perfFlushes <= r_perfFlushes + PERF_W'(1);
      end else if (bubble) begin
        r_perfBubbles <= r_perfBubbles + PERF_W'(1);
      end
    end
  end

  assign perf_bubbles = r_perfBubbles;
  assign perf_flushes = r_perfFlushes;
`endif

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Self-checking bench for ctrl_pipe_regs: a queue of expected stage contents is
// advanced alongside the stimulus and compared against the ex/mem/wb outputs.
module tb_ctrl_pipe_regs;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_alu_src, id_mem2reg, id_reg_write, id_mem_read, id_mem_write;
  logic       id_branch, id_jalr_mode, id_jal_mode, id_lui_mode;
  logic [3:0] id_write_enable;
  logic [4:0] id_read_enable;
  logic [1:0] id_aluop, id_writeback;
  logic [4:0] id_rd;
  logic       bubble, flush, stall_all;
  logic       ex_valid, ex_alu_src, ex_branch, ex_jalr_mode, ex_jal_mode, ex_lui_mode;
  logic [1:0] ex_aluop;
  logic       mem_valid, mem_mem_read, mem_mem_write, mem_reg_write;
  logic [3:0] mem_write_enable;
  logic [4:0] mem_read_enable;
  logic [4:0] mem_rd;
  logic       wb_valid, wb_reg_write, wb_mem2reg;
  logic [1:0] wb_writeback;
  logic [4:0] wb_rd;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perf_bubbles, perf_flushes;
`endif

  always #5 clk = ~clk;

  ctrl_pipe_regs #(.RD_W(5), .PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_alu_src(id_alu_src), .id_mem2reg(id_mem2reg),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_jalr_mode(id_jalr_mode), .id_jal_mode(id_jal_mode),
    .id_lui_mode(id_lui_mode), .id_write_enable(id_write_enable),
    .id_read_enable(id_read_enable), .id_aluop(id_aluop), .id_writeback(id_writeback),
    .id_rd(id_rd), .bubble(bubble), .flush(flush), .stall_all(stall_all),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_jalr_mode(ex_jalr_mode), .ex_jal_mode(ex_jal_mode), .ex_lui_mode(ex_lui_mode),
    .ex_aluop(ex_aluop), .mem_valid(mem_valid), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem2reg(wb_mem2reg),
    .wb_writeback(wb_writeback), .wb_rd(wb_rd)
`ifdef CTRL_PIPE_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  typedef struct packed {
    logic       valid;
    logic       aluSrc;
    logic       mem2reg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jalrMode;
    logic       jalMode;
    logic       luiMode;
    logic [3:0] writeEnable;
    logic [4:0] readEnable;
    logic [1:0] aluop;
    logic [1:0] writeback;
    logic [4:0] rd;
  } ctrl_t;

  // q[0] is the expected EX/MEM content, q[1] the expected ID/EX content.
  ctrl_t q[$];
  ctrl_t expWb;
  int    compared   = 0;
  int    mismatched = 0;
  int    perfB      = 0;
  int    perfF      = 0;

  function automatic ctrl_t sanitise(ctrl_t c);
    ctrl_t s;
    s = '0;
    if (c.valid) begin
      s = c;
      if (c.rd == 5'd0) s.regWrite = 1'b0;
    end
    return s;
  endfunction

  function automatic ctrl_t mkLoad(logic [4:0] rd);
    ctrl_t c;
    c = '0;
    c.valid = 1'b1; c.aluSrc = 1'b1; c.mem2reg = 1'b1; c.regWrite = 1'b1;
    c.memRead = 1'b1; c.readEnable = 5'b00100; c.writeback = 2'b01; c.rd = rd;
    return c;
  endfunction

  function automatic ctrl_t mkStore();
    ctrl_t c;
    c = '0;
    c.valid = 1'b1; c.aluSrc = 1'b1; c.memWrite = 1'b1; c.writeEnable = 4'hF; c.rd = 5'd3;
    return c;
  endfunction

  function automatic ctrl_t mkAdd(logic [4:0] rd);
    ctrl_t c;
    c = '0;
    c.valid = 1'b1; c.regWrite = 1'b1; c.aluop = 2'b10; c.writeback = 2'b00; c.rd = rd;
    return c;
  endfunction

  function automatic ctrl_t mkJal(logic [4:0] rd);
    ctrl_t c;
    c = '0;
    c.valid = 1'b1; c.regWrite = 1'b1; c.jalMode = 1'b1; c.branch = 1'b1;
    c.writeback = 2'b10; c.rd = rd;
    return c;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    ctrl_t e;
    ctrl_t m;
    e = q[1];
    m = q[0];
    checkVal("ex_stage",
             {24'd0, ex_valid, ex_alu_src, ex_branch, ex_jalr_mode, ex_jal_mode, ex_lui_mode, ex_aluop},
             {24'd0, e.valid, e.aluSrc, e.branch, e.jalrMode, e.jalMode, e.luiMode, e.aluop});
    checkVal("mem_stage",
             {14'd0, mem_valid, mem_mem_read, mem_mem_write, mem_write_enable, mem_read_enable,
              mem_reg_write, mem_rd},
             {14'd0, m.valid, m.memRead, m.memWrite, m.writeEnable, m.readEnable, m.regWrite, m.rd});
    checkVal("wb_stage",
             {22'd0, wb_valid, wb_reg_write, wb_mem2reg, wb_writeback, wb_rd},
             {22'd0, expWb.valid, expWb.regWrite, expWb.mem2reg, expWb.writeback, expWb.rd});
`ifdef CTRL_PIPE_PERF_EN
    checkVal("perf_bubbles", perf_bubbles, perfB);
    checkVal("perf_flushes", perf_flushes, perfF);
`endif
  endtask

  // Drive one edge worth of inputs, advance the expected pipe, then check.
  task automatic applyStimulus(input ctrl_t c, input logic b, input logic f,
                               input logic s, input logic r);
    ctrl_t entry;
    reset = r; bubble = b; flush = f; stall_all = s;
    id_valid = c.valid; id_alu_src = c.aluSrc; id_mem2reg = c.mem2reg;
    id_reg_write = c.regWrite; id_mem_read = c.memRead; id_mem_write = c.memWrite;
    id_branch = c.branch; id_jalr_mode = c.jalrMode; id_jal_mode = c.jalMode;
    id_lui_mode = c.luiMode; id_write_enable = c.writeEnable; id_read_enable = c.readEnable;
    id_aluop = c.aluop; id_writeback = c.writeback; id_rd = c.rd;
    @(posedge clk);
    if (r) begin
      q.delete();
      q.push_back('0);
      q.push_back('0);
      expWb = '0;
      perfB = 0;
      perfF = 0;
    end else if (!s) begin
      entry = (b || f) ? ctrl_t'('0) : sanitise(c);
      q.push_back(entry);
      expWb = q.pop_front();
      if (f) perfF++;
      else if (b) perfB++;
    end
    #1;
    checkOutput();
  endtask

  initial begin
    ctrl_t idle;
    ctrl_t rnd;
    logic [9:0] wbHeld;
    idle = '0;

    // Reset, with stall asserted on the second edge
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(idle, 1'b0, 1'b0, 1'b1, 1'b1);

    // Basic flow: load rd=7 then store
    applyStimulus(mkLoad(5'd7), 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("basic_ex_valid", {31'd0, ex_valid}, 32'd1);
    applyStimulus(mkStore(), 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("basic_mem_read", {31'd0, mem_mem_read}, 32'd1);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("basic_wb_rd", {27'd0, wb_rd}, 32'd7);
    checkVal("basic_wb_mem2reg", {31'd0, wb_mem2reg}, 32'd1);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("store_wb_reg_write", {30'd0, wb_valid, wb_reg_write}, 32'h2);

    // Load-use bubble: the dependent add is held and re-presented
    applyStimulus(mkLoad(5'd9), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkAdd(5'd4), 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("bubble_ex_nop", {24'd0, ex_valid, ex_alu_src, ex_branch, ex_jalr_mode,
                               ex_jal_mode, ex_lui_mode, ex_aluop}, 32'd0);
    checkVal("bubble_load_in_mem", {26'd0, mem_valid, mem_rd}, {26'd0, 1'b1, 5'd9});
    applyStimulus(mkAdd(5'd4), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush and bubble on the same edge: a single NOP
    applyStimulus(mkJal(5'd1), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkAdd(5'd5), 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(mkAdd(5'd6), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall with three entries in flight; a flush inside the stall is ignored
    applyStimulus(mkLoad(5'd10), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkAdd(5'd11), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkStore(), 1'b0, 1'b0, 1'b0, 1'b0);
    wbHeld = {wb_valid, wb_reg_write, wb_mem2reg, wb_writeback, wb_rd};
    applyStimulus(mkAdd(5'd12), 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(mkAdd(5'd12), 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(mkAdd(5'd12), 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("stall_wb_held", {22'd0, wb_valid, wb_reg_write, wb_mem2reg, wb_writeback, wb_rd},
             {22'd0, wbHeld});
    applyStimulus(mkAdd(5'd12), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);

    // Write to x0 keeps valid but drops reg_write
    applyStimulus(mkAdd(5'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("x0_wb", {30'd0, wb_valid, wb_reg_write}, 32'h2);

    // Reset mid-stall with a full pipe, then normal latency afterwards
    applyStimulus(mkLoad(5'd13), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkLoad(5'd14), 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(mkAdd(5'd15), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkAdd(5'd16), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkAdd(5'd17), 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(mkAdd(5'd17), 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("reset_all_zero", {9'd0, ex_valid, ex_aluop, mem_valid, mem_mem_read, mem_mem_write,
                                mem_write_enable, mem_read_enable, wb_valid, wb_reg_write, wb_rd},
             32'd0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkAdd(5'd18), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("post_reset_wb", {26'd0, wb_valid, wb_rd}, {26'd0, 1'b1, 5'd18});

    // Mixed random traffic with occasional hazards and stalls
    for (int i = 0; i < 80; i++) begin
      rnd = ctrl_t'($urandom);
      applyStimulus(rnd, ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 4) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
